// File: rtl/pin_input_debouncer.sv
// Pin debouncer: 2-flop synchronizer followed by a four-state qualification FSM
// that commits a new level only after DEBOUNCE_CYCLES+1 consecutive agreeing samples.
module pin_input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 12000,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int unsigned     CW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   C_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   C_ONE = CW'(1);

   localparam logic [1:0] STABLE_LO = 2'd0;
   localparam logic [1:0] QUAL_HI   = 2'd1;
   localparam logic [1:0] STABLE_HI = 2'd2;
   localparam logic [1:0] QUAL_LO   = 2'd3;
   localparam logic [1:0] RESET_ST  = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   logic          r_s1;
   logic          r_s2;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;

   logic [1:0]    w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_level_nxt;
   logic          w_rise_nxt;
   logic          w_fall_nxt;

   // The counter only ever holds 0 (stable) or 1..DEBOUNCE_CYCLES (qualifying).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         STABLE_LO: begin
            if (r_s2) begin
               w_state_nxt = QUAL_HI;
               w_cnt_nxt   = C_ONE;
            end
         end
         QUAL_HI: begin
            if (!r_s2) begin
               w_state_nxt = STABLE_LO;
            end else if (r_cnt == C_MAX) begin
               w_state_nxt = STABLE_HI;
               w_level_nxt = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + C_ONE;
            end
         end
         STABLE_HI: begin
            if (!r_s2) begin
               w_state_nxt = QUAL_LO;
               w_cnt_nxt   = C_ONE;
            end
         end
         QUAL_LO: begin
            if (r_s2) begin
               w_state_nxt = STABLE_HI;
            end else if (r_cnt == C_MAX) begin
               w_state_nxt = STABLE_LO;
               w_level_nxt = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + C_ONE;
            end
         end
         default: begin
            w_state_nxt = RESET_ST;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= RESET_LEVEL;
         r_s2    <= RESET_LEVEL;
         r_state <= RESET_ST;
         r_cnt   <= '0;
         r_level <= RESET_LEVEL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_s1    <= pin;
         r_s2    <= r_s1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;
   assign busy  = (r_state == QUAL_HI) || (r_state == QUAL_LO);

endmodule

// File: tb/tb_pin_input_debouncer.sv
// Bench for pin_input_debouncer: DEBOUNCE_CYCLES=4 and =1 instances share one pin,
// checked every cycle against a sliding-window reference plus fixed-latency directed checks.
module tb_pin_input_debouncer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pin = 1'b0;

   logic level4, rise4, fall4, busy4;
   logic level1, rise1, fall1, busy1;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 clk = ~clk;

   pin_input_debouncer #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .pin(pin),
      .level(level4), .rise(rise4), .fall(fall4), .busy(busy4)
   );

   pin_input_debouncer #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pin(pin),
      .level(level1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   // Reference: hist[i] is the pin value sampled i edges ago. The FSM acts on the
   // sample taken two edges earlier; a level flips once D+1 such samples disagree.
   logic [15:0] hist;
   logic [15:0] w_nh;
   logic        ml4, mr4, mf4;
   logic        ml1, mr1, mf1;

   assign w_nh = {hist[14:0], pin};

   function automatic logic qual(input logic [15:0] h, input int unsigned d, input logic lvl);
      logic ok;
      ok = 1'b1;
      for (int unsigned j = 0; j <= d; j++)
         if (h[2+j] == lvl) ok = 1'b0;
      return ok;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0;
         ml4 <= 1'b0; mr4 <= 1'b0; mf4 <= 1'b0;
         ml1 <= 1'b0; mr1 <= 1'b0; mf1 <= 1'b0;
      end else begin
         hist <= w_nh;
         mr4 <= 1'b0; mf4 <= 1'b0;
         mr1 <= 1'b0; mf1 <= 1'b0;
         if (qual(w_nh, 4, ml4)) begin
            ml4 <= ~ml4; mr4 <= ~ml4; mf4 <= ml4;
         end
         if (qual(w_nh, 1, ml1)) begin
            ml1 <= ~ml1; mr1 <= ~ml1; mf1 <= ml1;
         end
      end
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic check_model();
      check_bit("level4", level4, ml4);
      check_bit("rise4",  rise4,  mr4);
      check_bit("fall4",  fall4,  mf4);
      check_bit("busy4",  busy4,  rst_n && (hist[2] != ml4));
      check_bit("level1", level1, ml1);
      check_bit("rise1",  rise1,  mr1);
      check_bit("fall1",  fall1,  mf1);
      check_bit("busy1",  busy1,  rst_n && (hist[2] != ml1));
   endtask

   // Check at the falling edge, then drive the next pin value.
   task automatic tick(input logic v);
      @(negedge clk);
      check_model();
      pin = v;
   endtask

   // Pin already driven to 1 from a stable-low state; edge n is the n-th edge sampling it.
   task automatic latency_rise(input string tag);
      for (int unsigned n = 1; n <= 9; n++) begin
         tick(1'b1);
         check_bit({tag, "_lvl4"},  level4, n >= 7);
         check_bit({tag, "_rise4"}, rise4,  n == 7);
         check_bit({tag, "_busy4"}, busy4,  (n >= 3) && (n <= 6));
         check_bit({tag, "_lvl1"},  level1, n >= 4);
         check_bit({tag, "_rise1"}, rise1,  n == 4);
      end
   endtask

   initial begin
      int unsigned run;
      logic v;

      pin = 1'b0;
      rst_n = 1'b0;
      #1;
      check_bit("rst_level4", level4, 1'b0);
      check_bit("rst_busy4",  busy4,  1'b0);
      check_bit("rst_level1", level1, 1'b0);
      repeat (3) tick(1'b0);
      rst_n = 1'b1;
      repeat (6) tick(1'b0);

      // Clean rise with fixed latency.
      tick(1'b1);
      latency_rise("clean");

      // Fall after stable high.
      tick(1'b0);
      for (int unsigned n = 1; n <= 9; n++) begin
         tick(1'b0);
         check_bit("fall_lvl4",  level4, n < 7);
         check_bit("fall_fall4", fall4,  n == 7);
         check_bit("fall_rise4", rise4,  1'b0);
         check_bit("fall_lvl1",  level1, n < 4);
      end

      // Glitch: 3 cycles high, then low.
      repeat (3) tick(1'b1);
      repeat (12) begin
         tick(1'b0);
         check_bit("glitch_lvl4", level4, 1'b0);
         check_bit("glitch_rise4", rise4, 1'b0);
      end
      check_bit("glitch_busy4", busy4, 1'b0);

      // Single-cycle pulse rejected by the D=1 instance.
      tick(1'b1);
      repeat (8) begin
         tick(1'b0);
         check_bit("pulse_lvl1", level1, 1'b0);
         check_bit("pulse_rise1", rise1, 1'b0);
      end

      // Bounce every 2 cycles for 40 cycles, then settle high.
      for (int unsigned i = 0; i < 40; i++) begin
         tick(((i / 2) % 2) == 0);
         check_bit("bounce_lvl4", level4, 1'b0);
      end
      repeat (12) tick(1'b1);
      check_bit("bounce_lvl4_end", level4, 1'b1);
      repeat (8) tick(1'b0);

      // Random runs of random length.
      for (int unsigned i = 0; i < 120; i++) begin
         v = 1'($urandom_range(0, 1));
         run = $urandom_range(1, 8);
         repeat (run) tick(v);
      end

      // Settle low, then reset mid-qualification.
      repeat (12) tick(1'b0);
      tick(1'b1);
      repeat (3) tick(1'b1);
      check_bit("midq_busy4_pre", busy4, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("midq_busy4",  busy4,  1'b0);
      check_bit("midq_level4", level4, 1'b0);
      check_bit("midq_rise4",  rise4,  1'b0);
      check_bit("midq_busy1",  busy1,  1'b0);
      check_bit("midq_level1", level1, 1'b0);
      repeat (4) begin
         tick(1'b1);
         check_bit("inrst_rise4", rise4, 1'b0);
         check_bit("inrst_level1", level1, 1'b0);
      end
      rst_n = 1'b1;
      latency_rise("postrst");
      repeat (4) tick(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pin_input_debouncer.md
PIN_INPUT_DEBOUNCER -- requirements
Module: pin_input_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 12000, giving the stability window in clk cycles (1 ms at 12 MHz); legal range 1..2^20.
REQ-002 SHALL have parameter RESET_LEVEL, default 1'b0, giving the debounced level assumed after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pin, input, 1 bit: raw asynchronous level from a board pin or button.
REQ-006 SHALL have port level, output, 1 bit: the debounced, synchronous level.
REQ-007 SHALL have port rise, output, 1 bit: a one-cycle pulse when level goes 0->1.
REQ-008 SHALL have port fall, output, 1 bit: a one-cycle pulse when level goes 1->0.
REQ-009 SHALL have port busy, output, 1 bit: high while a candidate transition is being qualified.

Function
REQ-010 SHALL pass pin through a 2-flop synchronizer (s1, s2); only s2 feeds the logic below.
REQ-011 SHALL implement the FSM states STABLE_LO, QUAL_HI, STABLE_HI and QUAL_LO.
REQ-012 STABLE_LO: on s2=1, go to QUAL_HI with counter=1; otherwise stay with counter=0.
REQ-013 QUAL_HI: on s2=0, return to STABLE_LO with counter=0 (glitch rejected, no pulse).
REQ-014 QUAL_HI: on s2=1 and counter=DEBOUNCE_CYCLES, go to STABLE_HI, set level=1, pulse rise, counter=0.
REQ-015 QUAL_HI: on s2=1 and counter<DEBOUNCE_CYCLES, increment the counter.
REQ-016 STABLE_HI and QUAL_LO SHALL mirror REQ-012..015 with polarities swapped; the qualifying exit pulses fall.
REQ-017 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, SHALL never wrap, and SHALL never exceed DEBOUNCE_CYCLES.
REQ-018 Latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the edge that first samples the new pin value into s1 to the edge that updates level, provided pin is held.
REQ-019 rise and fall SHALL be registered, asserted in the same cycle level changes, high for exactly 1 cycle, and never high together.
REQ-020 busy SHALL be 1 exactly in QUAL_HI and QUAL_LO.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES+1 cycles at s2 SHALL produce no change on level, rise or fall.
REQ-022 With DEBOUNCE_CYCLES=1, a transition SHALL require s2 stable for 2 consecutive edges.
REQ-023 Continuous toggling faster than the window SHALL leave level constant indefinitely.

Reset
REQ-024 While rst_n=0, SHALL set s1=s2=RESET_LEVEL, level=RESET_LEVEL, rise=fall=busy=0, counter=0, and state STABLE_LO (or STABLE_HI if RESET_LEVEL=1), independent of clk.
REQ-025 Reset asserted mid-qualification SHALL abandon the candidate; no pulse SHALL be emitted during or after reset for that candidate.
REQ-026 After release of rst_n, a pin held at the non-reset level SHALL qualify normally with latency per REQ-018.

Verification (DEBOUNCE_CYCLES=4, RESET_LEVEL=0)
REQ-027 Clean rise: pin 0->1 and held -> level=1 and rise=1 for one cycle exactly 7 edges after first sample; busy high for the preceding 4 cycles.
REQ-028 Glitch: pin high for 3 cycles then low -> level stays 0; rise and fall never assert; busy returns to 0.
REQ-029 Bounce: pin toggles every 2 cycles for 40 cycles then settles at 1 -> exactly one rise pulse, 7 edges after settling.
REQ-030 Fall after stable high: pin 1->0 and held -> fall pulse and level=0 at latency 7; rise stays 0.
REQ-031 Mid-qualification reset: rst_n=0 asynchronously while busy=1 -> outputs go to reset values immediately; after release with pin=1 held, rise arrives 7 edges after the first post-reset sample.
REQ-032 Bound check: DEBOUNCE_CYCLES=1 -> level follows a held change at latency 4; a 1-cycle pulse at s2 is rejected.
